// File: rtl/scope_pkg.sv
// Shared definitions for the scope capture buffer: state encoding and width.
// Readout control imports these so both sides decode `state` the same way.
package scope_pkg;

  localparam int ST_W = 2;

  typedef enum logic [ST_W-1:0] {
    ST_FILL  = 2'd0,
    ST_ARMED = 2'd1,
    ST_POST  = 2'd2,
    ST_DONE  = 2'd3
  } scope_state_t;

endpackage

// File: rtl/scope_mem.sv
// Sample storage for the capture buffer.
// Writes are synchronous and reads are asynchronous, so dout follows the read pointer within the same cycle.
module scope_mem #(
  parameter int AW = 4,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem_reg [2**AW];

  always_ff @(posedge clk) begin
    if (we) mem_reg[waddr] <= wdata;
  end

  assign rdata = mem_reg[raddr];

endmodule

// File: rtl/scope_buffer_mc.sv
// Multi-channel scope capture buffer: decimated capture, pre-trigger fill, post-trigger count,
// trigger-position report and FIFO readout once capture has finished.
module scope_buffer_mc
  import scope_pkg::*;
#(
  parameter int N     = 8,
  parameter int NCH   = 2,
  parameter int NSAMP = 4,
  parameter int DECW  = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              rearm,
  input  logic              trigger,
  input  logic              halt,
  input  logic [NSAMP-1:0]  npre,
  input  logic [NSAMP-1:0]  npost,
  input  logic [DECW-1:0]   decim,
  input  logic [NCH*N-1:0]  din,
  input  logic              din_latch,
  output logic [ST_W-1:0]   state,
  output logic              triggered,
  output logic              done,
  output logic [NSAMP:0]    count,
  output logic [NSAMP-1:0]  tpos,
  output logic [NCH*N-1:0]  dout,
  output logic              dout_ready,
  input  logic              dout_pop
);

  localparam logic [NSAMP:0] CNT_MAX = (NSAMP+1)'((2**NSAMP) - 1);

  scope_state_t     state_reg, state_next;
  logic             triggered_reg, triggered_next;
  logic [NSAMP:0]   count_reg, count_next;
  logic [NSAMP:0]   post_held_reg, post_held_next;
  logic [NSAMP-1:0] postcnt_reg, postcnt_next;
  logic [NSAMP-1:0] wptr_reg, wptr_next;
  logic [NSAMP-1:0] rptr_reg, rptr_next;
  logic [NSAMP-1:0] tpos_reg, tpos_next;
  logic [DECW-1:0]  dcnt_reg, dcnt_next;
  logic             accept;
  logic             store;
  logic             pop_ok;

  // halt outranks trigger; a zero-length post capture leaves the trigger-cycle sample out.
  assign accept = (state_reg == ST_ARMED) && trigger && !halt;
  assign store  = din_latch && (dcnt_reg == '0) && (state_reg != ST_DONE) && !rearm
                  && !(accept && (npost == '0));
  assign pop_ok = dout_pop && (state_reg == ST_DONE) && (count_reg != '0);

  always_comb begin
    state_next     = state_reg;
    triggered_next = triggered_reg;
    count_next     = count_reg;
    post_held_next = post_held_reg;
    postcnt_next   = postcnt_reg;
    wptr_next      = wptr_reg;
    rptr_next      = rptr_reg;
    tpos_next      = tpos_reg;
    dcnt_next      = dcnt_reg;

    if (din_latch && (state_reg != ST_DONE)) begin
      dcnt_next = (dcnt_reg == decim) ? '0 : dcnt_reg + 1'b1;
    end
    if (accept) dcnt_next = '0;

    if (store) begin
      wptr_next = wptr_reg + 1'b1;
      if (count_reg == CNT_MAX) rptr_next = rptr_reg + 1'b1;
      else                      count_next = count_reg + 1'b1;
    end
    if (pop_ok) begin
      rptr_next  = rptr_reg + 1'b1;
      count_next = count_reg - 1'b1;
    end

    // post_held tracks post-trigger words still in the buffer, capped once they fill it
    if (accept) begin
      post_held_next = store ? (NSAMP+1)'(1) : '0;
    end else if (store && (state_reg == ST_POST)) begin
      if (!((count_reg == CNT_MAX) && (post_held_reg == count_reg))) begin
        post_held_next = post_held_reg + 1'b1;
      end
    end

    case (state_reg)
      ST_FILL: begin
        if (halt) begin
          state_next = ST_DONE;
          tpos_next  = count_next[NSAMP-1:0];
        end else if (count_next >= {1'b0, npre}) begin
          state_next = ST_ARMED;
        end
      end
      ST_ARMED: begin
        if (halt) begin
          state_next = ST_DONE;
          tpos_next  = count_next[NSAMP-1:0];
        end else if (accept) begin
          triggered_next = 1'b1;
          if (npost == '0) begin
            state_next = ST_DONE;
            tpos_next  = count_next[NSAMP-1:0];
          end else if (store && (npost == NSAMP'(1))) begin
            state_next = ST_DONE;
            tpos_next  = NSAMP'(count_next - post_held_next);
          end else begin
            state_next   = ST_POST;
            postcnt_next = store ? npost - 1'b1 : npost;
          end
        end
      end
      ST_POST: begin
        if (halt) begin
          state_next = ST_DONE;
          tpos_next  = count_next[NSAMP-1:0];
        end else if (store) begin
          postcnt_next = postcnt_reg - 1'b1;
          if (postcnt_reg == NSAMP'(1)) begin
            state_next = ST_DONE;
            tpos_next  = NSAMP'(count_next - post_held_next);
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n || rearm) begin
      state_reg     <= ST_FILL;
      triggered_reg <= 1'b0;
      count_reg     <= '0;
      post_held_reg <= '0;
      postcnt_reg   <= '0;
      wptr_reg      <= '0;
      rptr_reg      <= '0;
      tpos_reg      <= '0;
      dcnt_reg      <= '0;
    end else begin
      state_reg     <= state_next;
      triggered_reg <= triggered_next;
      count_reg     <= count_next;
      post_held_reg <= post_held_next;
      postcnt_reg   <= postcnt_next;
      wptr_reg      <= wptr_next;
      rptr_reg      <= rptr_next;
      tpos_reg      <= tpos_next;
      dcnt_reg      <= dcnt_next;
    end
  end

  scope_mem #(
    .AW (NSAMP),
    .DW (NCH*N)
  ) u_mem (
    .clk   (clk),
    .we    (store && reset_n),
    .waddr (wptr_reg),
    .wdata (din),
    .raddr (rptr_reg),
    .rdata (dout)
  );

  assign state      = state_reg;
  assign triggered  = triggered_reg;
  assign done       = (state_reg == ST_DONE);
  assign count      = count_reg;
  assign tpos       = tpos_reg;
  assign dout_ready = done && (count_reg != '0);

endmodule
